// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, holds the word for decode.
// Optional one-entry prefetch buffer enabled by defining PREFETCH_BUF_EN.
module instr_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_INC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus8,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_target
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_drop_addr, w_drop_nxt;
  logic [31:0]       r_instr, w_instr_nxt;
  logic [ADDR_W-1:0] r_instr_pc, w_ipc_nxt;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;

`ifdef PREFETCH_BUF_EN
  logic              r_buf_valid, w_bv_nxt;
  logic [31:0]       r_buf_data, w_bd_nxt;
  logic [ADDR_W-1:0] r_buf_pc, w_bp_nxt;
`endif

  assign w_target = pc_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign w_pc_inc = r_pc + ADDR_W'(PC_INC);

  assign instr    = r_instr;
  assign instr_pc = r_instr_pc;
  assign pc_plus8 = r_instr_pc + ADDR_W'(8);
  assign cond     = r_instr[31:28];
  assign op       = r_instr[27:26];
  assign funct    = r_instr[25:20];
  assign rd       = r_instr[15:12];

  always_comb begin
    w_next      = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop_addr;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_instr_pc;
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    instr_valid = 1'b0;
`ifdef PREFETCH_BUF_EN
    w_bv_nxt    = r_buf_valid;
    w_bd_nxt    = r_buf_data;
    w_bp_nxt    = r_buf_pc;
`endif
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        // A redirect with no ack leaves a request in flight that must be drained.
        if (pc_src) begin
          w_pc_nxt   = w_target;
          w_drop_nxt = r_pc;
          w_next     = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_ipc_nxt   = r_pc;
          w_pc_nxt    = w_pc_inc;
          w_next      = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
`ifdef PREFETCH_BUF_EN
        imem_req = ~r_buf_valid;
        if (pc_src) begin
          w_pc_nxt   = w_target;
          w_bv_nxt   = 1'b0;
          w_drop_nxt = r_pc;
          w_next     = (imem_req && !imem_ack) ? S_DROP : S_REQ;
        end else if (instr_ready) begin
          if (r_buf_valid) begin
            w_instr_nxt = r_buf_data;
            w_ipc_nxt   = r_buf_pc;
            w_bv_nxt    = 1'b0;
          end else if (imem_ack) begin
            w_instr_nxt = imem_rdata;
            w_ipc_nxt   = r_pc;
            w_pc_nxt    = w_pc_inc;
          end else begin
            // Prefetch still pending; S_REQ keeps the same request asserted.
            w_next = S_REQ;
          end
        end else if (imem_req && imem_ack) begin
          w_bv_nxt = 1'b1;
          w_bd_nxt = imem_rdata;
          w_bp_nxt = r_pc;
          w_pc_nxt = w_pc_inc;
        end
`else
        if (pc_src) begin
          w_pc_nxt = w_target;
          w_next   = S_REQ;
        end else if (instr_ready) begin
          w_next = S_REQ;
        end
`endif
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = r_drop_addr;
        if (pc_src) w_pc_nxt = w_target;
        if (imem_ack) w_next = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
`ifdef PREFETCH_BUF_EN
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_pc    <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_pc  <= w_ipc_nxt;
`ifdef PREFETCH_BUF_EN
      r_buf_valid <= w_bv_nxt;
      r_buf_data  <= w_bd_nxt;
      r_buf_pc    <= w_bp_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with configurable wait states,
// stream-level reference model checked every cycle, plus directed literal checks.
module tb_instr_fetch;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [3:0]    cond;
  logic [1:0]    op;
  logic [5:0]    funct;
  logic [3:0]    rd;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc_plus8;
  logic          pc_src = 1'b0;
  logic [AW-1:0] pc_target = '0;

  int n_checks = 0;
  int n_err    = 0;
  int wait_st  = 0;
  int cnt      = 0;
  logic [AW-1:0] fetch_q[$];

  instr_fetch #(.ADDR_W(AW), .RESET_PC('0), .PC_INC(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .cond(cond), .op(op), .funct(funct), .rd(rd),
    .instr_pc(instr_pc), .pc_plus8(pc_plus8),
    .pc_src(pc_src), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (a == '0) ? 32'hE0811002 : (32'hC000_0000 | a);
  endfunction

  // Memory: ack once the request has waited wait_st cycles (0 = same cycle).
  assign imem_ack   = imem_req && (cnt >= wait_st);
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the delivered stream is sequential from RESET_PC, restarting at the
  // (word-aligned) target of the most recent redirect; each word equals memory at its PC.
  logic [AW-1:0] exp_pc;
  logic          prev_pend;
  logic [AW-1:0] prev_addr;
  logic          redir_prev;
  logic [31:0]   mw;
  initial begin
    exp_pc = '0; prev_pend = 1'b0; prev_addr = '0; redir_prev = 1'b0; mw = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_pc = '0; prev_pend = 1'b0; redir_prev = 1'b0;
      end else begin
        if (redir_prev) chk("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
        if (prev_pend) begin
          chk("req_held", {31'b0, imem_req}, 32'd1);
          chk("addr_held", imem_addr, prev_addr);
        end
        if (instr_valid) begin
          mw = mem_word(exp_pc);
          chk("instr_pc", instr_pc, exp_pc);
          chk("instr", instr, mw);
          chk("cond", {28'b0, cond}, {28'b0, mw[31:28]});
          chk("op", {30'b0, op}, {30'b0, mw[27:26]});
          chk("funct", {26'b0, funct}, {26'b0, mw[25:20]});
          chk("rd", {28'b0, rd}, {28'b0, mw[15:12]});
          chk("pc_plus8", pc_plus8, exp_pc + 32'd8);
        end
        if (imem_req && imem_ack) fetch_q.push_back(imem_addr);
        prev_pend  = imem_req && !imem_ack;
        prev_addr  = imem_addr;
        redir_prev = pc_src;
        if (pc_src) exp_pc = pc_target & 32'hFFFF_FFFC;
        else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w, input logic rdy);
    reset = 1'b0; pc_src = 1'b0; pc_target = '0;
    instr_ready = rdy; wait_st = w;
    repeat (2) step();
    fetch_q.delete();
    reset = 1'b1;
  endtask

  task automatic wait_pc(input logic [AW-1:0] pc);
    int k;
    k = 0;
    while (!(instr_valid && instr_pc == pc) && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  logic [5:0]    vbits;
  logic [AW-1:0] vq[$];
  logic [31:0]   saved;
  logic          seen_c;

  initial begin
    vbits = '0; saved = '0; seen_c = 1'b0;

    // Reset release, zero-wait memory.
    do_reset(0, 1'b0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    step();
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    chk("c1_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("c2_cond", {28'b0, cond}, 32'hE);
    chk("c2_op", {30'b0, op}, 32'h0);
    chk("c2_funct", {26'b0, funct}, 32'h08);
    chk("c2_rd", {28'b0, rd}, 32'h1);
    chk("c2_instr_pc", instr_pc, 32'd0);
    chk("c2_pc_plus8", pc_plus8, 32'd8);
    step();
    chk("c3_held_valid", {31'b0, instr_valid}, 32'd1);
    chk("c3_no_req", {31'b0, imem_req}, 32'd0);

    // Three sequential fetches with decode always ready.
    do_reset(0, 1'b1);
    vq.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      vbits[i] = instr_valid;
      if (instr_valid) vq.push_back(instr_pc);
    end
`ifdef PREFETCH_BUF_EN
    chk("seq_valid_pattern", {26'b0, vbits}, 32'b111110);
`else
    chk("seq_valid_pattern", {26'b0, vbits}, 32'b101010);
`endif
    chk("seq_nfetch_ge3", {31'b0, fetch_q.size() >= 3}, 32'd1);
    chk("seq_nvalid_ge3", {31'b0, vq.size() >= 3}, 32'd1);
    if (fetch_q.size() >= 3 && vq.size() >= 3) begin
      chk("seq_addr0", fetch_q[0], 32'd0);
      chk("seq_addr1", fetch_q[1], 32'd4);
      chk("seq_addr2", fetch_q[2], 32'd8);
      chk("seq_ipc0", vq[0], 32'd0);
      chk("seq_ipc1", vq[1], 32'd4);
      chk("seq_ipc2", vq[2], 32'd8);
    end

    // Slow memory: request held three cycles, ack on the third.
    do_reset(2, 1'b0);
    step();
    chk("slow_c1_req", {31'b0, imem_req}, 32'd1);
    chk("slow_c1_ack", {31'b0, imem_ack}, 32'd0);
    step();
    chk("slow_c2_addr", imem_addr, 32'd0);
    chk("slow_c2_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("slow_c3_ack", {31'b0, imem_ack}, 32'd1);
    chk("slow_c3_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("slow_c4_valid", {31'b0, instr_valid}, 32'd1);
    chk("slow_c4_instr", instr, 32'hE0811002);

    // Redirect while holding the instruction at 0x8.
    do_reset(0, 1'b1);
    wait_pc(32'h8);
    pc_src = 1'b1; pc_target = 32'h100;
    step();
    pc_src = 1'b0;
    chk("hold_redir_addr", imem_addr, 32'h100);
    chk("hold_redir_req", {31'b0, imem_req}, 32'd1);
    chk("hold_redir_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("hold_redir_ipc", instr_pc, 32'h100);
`ifndef PREFETCH_BUF_EN
    seen_c = 1'b0;
    foreach (fetch_q[i]) if (fetch_q[i] == 32'hC) seen_c = 1'b1;
    chk("hold_redir_no_0xC", {31'b0, seen_c}, 32'd0);
`endif

    // Redirect two cycles into a four-cycle fetch of 0x10; unaligned target.
    do_reset(0, 1'b1);
    wait_pc(32'hC);
    wait_st = 3;
    step();
    chk("drop_c1_addr", imem_addr, 32'h10);
    saved = instr;
    step();
    pc_src = 1'b1; pc_target = 32'h43;
    step();
    pc_src = 1'b0;
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    chk("drop_addr_stale", imem_addr, 32'h10);
    chk("drop_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("drop_ack", {31'b0, imem_ack}, 32'd1);
    chk("drop_ack_addr", imem_addr, 32'h10);
    step();
    chk("drop_new_addr", imem_addr, 32'h40);
    chk("drop_instr_kept", instr, saved);
    chk("drop_new_valid", {31'b0, instr_valid}, 32'd0);
    wait_st = 0;
    step();
    chk("drop_land_valid", {31'b0, instr_valid}, 32'd1);
    chk("drop_land_ipc", instr_pc, 32'h40);
    chk("drop_land_instr", instr, 32'hC000_0040);

    // Asynchronous reset in the middle of a pending request.
    do_reset(3, 1'b1);
    step();
    step();
    chk("mid_req_before", {31'b0, imem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    step();
    step();
    reset = 1'b1;
    chk("mid_rel_idle_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("mid_rel_req", {31'b0, imem_req}, 32'd1);
    chk("mid_rel_addr", imem_addr, 32'd0);
    wait_st = 0;
    step();
    chk("mid_rel_valid", {31'b0, instr_valid}, 32'd1);
    chk("mid_rel_ipc", instr_pc, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
